// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction-fetch initiator for the RV32I core.
// Presents the PC to a combinational instruction memory and captures the
// returned word into the IF/ID register. Handles sequential advance,
// branch/jump redirects, stall hold and misaligned/out-of-range fetch faults.
// The fault flag is sticky, and the only way out of a fault is reset.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 8,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic [31:0] instr_in,
  output logic [31:0] pc_out,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instr,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  // One past the last legal fetch byte address.
  localparam logic [31:0] PC_LIMIT = 32'(4 * IMEM_DEPTH);

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic        if_valid_r;
  logic [31:0] if_pc_r;
  logic [31:0] if_pc_plus4_r;
  logic [31:0] if_instr_r;
  logic        fetch_fault_r;
  logic [31:0] fetch_count_r;

  logic        target_ok_s;
  logic        pc_in_range_s;
  logic [31:0] pc_plus4_s;

  // A fetch address is usable only if word-aligned and inside the memory.
  function automatic logic addr_legal(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) && (addr < PC_LIMIT);
  endfunction

  // Decode of the redirect target and of the current PC for this cycle.
  always_comb begin
    target_ok_s   = addr_legal(redirect_target);
    pc_in_range_s = (pc_r < PC_LIMIT);
    pc_plus4_s    = pc_r + 32'd4;
  end

  // Fetch state machine and IF/ID register; redirect beats stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= BOOT;
      pc_r          <= RESET_PC;
      if_valid_r    <= 1'b0;
      if_pc_r       <= 32'd0;
      if_pc_plus4_r <= 32'd0;
      if_instr_r    <= NOP_INSTR;
      fetch_fault_r <= 1'b0;
      fetch_count_r <= 32'd0;
    end else begin
      case (state_r)
        BOOT: begin
          state_r <= RUN;
        end
        RUN: begin
          if (redirect_valid) begin
            if (target_ok_s) begin
              pc_r       <= redirect_target;
              if_valid_r <= 1'b0;
              if_instr_r <= NOP_INSTR;
            end else begin
              if_valid_r    <= 1'b0;
              fetch_fault_r <= 1'b1;
              state_r       <= HALT;
            end
          end else if (stall) begin
            state_r <= RUN;
          end else if (!pc_in_range_s) begin
            if_valid_r    <= 1'b0;
            fetch_fault_r <= 1'b1;
            state_r       <= HALT;
          end else begin
            if_pc_r       <= pc_r;
            if_pc_plus4_r <= pc_plus4_s;
            if_instr_r    <= instr_in;
            if_valid_r    <= 1'b1;
            pc_r          <= pc_plus4_s;
            fetch_count_r <= fetch_count_r + 32'd1;
          end
        end
        HALT: begin
          state_r <= HALT;
        end
        default: begin
          // Corrupted state encoding: stop fetching and flag it.
          if_valid_r    <= 1'b0;
          fetch_fault_r <= 1'b1;
          state_r       <= HALT;
        end
      endcase
    end
  end

  assign pc_out      = pc_r;
  assign if_valid    = if_valid_r;
  assign if_pc       = if_pc_r;
  assign if_pc_plus4 = if_pc_plus4_r;
  assign if_instr    = if_instr_r;
  assign fetch_fault = fetch_fault_r;
  assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_ifetch_unit.sv
// Testbench for ifetch_unit: directed scenarios plus randomized sessions,
// all checked every cycle against a transaction-level reference model.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] instr_in;
  logic [31:0] pc_out;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  logic [31:0] mem [8];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: what the fetch unit should present.
  logic [31:0] m_pc, m_ifpc, m_ifpc4, m_instr, m_count;
  logic        m_valid, m_fault;
  int          m_phase; // 0 = boot cycle pending, 1 = fetching, 2 = halted

  ifetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_DEPTH(8),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .instr_in       (instr_in),
    .pc_out         (pc_out),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .if_instr       (if_instr),
    .fetch_fault    (fetch_fault),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  // Combinational instruction memory.
  always_comb begin
    instr_in = 32'hdead_beef;
    if (pc_out < 32'd32) instr_in = mem[pc_out[4:2]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'd0; m_ifpc = 32'd0; m_ifpc4 = 32'd0; m_instr = 32'h13;
    m_count = 32'd0; m_valid = 1'b0; m_fault = 1'b0; m_phase = 0;
  endtask

  // One rising edge worth of the fetch rules.
  task automatic model_step(input logic rv, input logic [31:0] tgt, input logic st);
    if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (rv) begin
        if (tgt[1:0] != 2'b00 || tgt >= 32'd32) begin
          m_valid = 1'b0; m_fault = 1'b1; m_phase = 2;
        end else begin
          m_pc = tgt; m_valid = 1'b0; m_instr = 32'h13;
        end
      end else if (!st) begin
        if (m_pc >= 32'd32) begin
          m_valid = 1'b0; m_fault = 1'b1; m_phase = 2;
        end else begin
          m_ifpc  = m_pc;
          m_ifpc4 = m_pc + 32'd4;
          m_instr = mem[m_pc[4:2]];
          m_valid = 1'b1;
          m_pc    = m_pc + 32'd4;
          m_count = m_count + 32'd1;
        end
      end
    end
  endtask

  task automatic check_all();
    check("pc_out",      pc_out,              m_pc);
    check("if_valid",    {31'd0, if_valid},   {31'd0, m_valid});
    check("if_pc",       if_pc,               m_ifpc);
    check("if_pc_plus4", if_pc_plus4,         m_ifpc4);
    check("if_instr",    if_instr,            m_instr);
    check("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
    check("fetch_count", fetch_count,         m_count);
  endtask

  // Drive inputs for the next edge, step DUT and model, compare at negedge.
  task automatic cycle(input logic rv, input logic [31:0] tgt, input logic st);
    redirect_valid  = rv;
    redirect_target = tgt;
    stall           = st;
    @(posedge clk);
    model_step(rv, tgt, st);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    redirect_valid = 1'b0; redirect_target = 32'd0; stall = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = $urandom;
    reset = 1'b1;
    model_reset();
    #2;
    check_all();
    @(negedge clk);
    reset = 1'b0;
    check_all();
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    case ($urandom_range(0, 9))
      0:       t = $urandom;
      1:       t = {$urandom_range(8, 200), 2'b00};
      2:       t = {27'd0, $urandom_range(0, 7), 2'b01};
      default: t = {27'd0, $urandom_range(0, 7), 2'b00};
    endcase
    return t;
  endfunction

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'd0;
    for (int i = 0; i < 8; i++) mem[i] = 32'd0;

    // Straight-line run to the end of memory, then range fault.
    do_reset();
    idle(1);
    check("boot_no_valid", {31'd0, if_valid}, 32'd0);
    idle(8);
    check("count_after_28", fetch_count, 32'd8);
    check("pc_at_end", pc_out, 32'd32);
    idle(1);
    check("range_fault", {31'd0, fetch_fault}, 32'd1);
    idle(2);

    // Stall held three cycles while if_pc = 8.
    do_reset();
    idle(4);
    check("pre_stall_ifpc", if_pc, 32'd8);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 32'd0, 1'b1);
      check("stall_pc", pc_out, 32'd12);
      check("stall_ifpc", if_pc, 32'd8);
    end
    idle(1);
    check("resume_ifpc", if_pc, 32'd12);

    // Redirect to 8 while pc_out = 16, then redirect+stall to 20.
    do_reset();
    idle(5);
    check("pre_redir_pc", pc_out, 32'd16);
    cycle(1'b1, 32'd8, 1'b0);
    check("redir_bubble", {31'd0, if_valid}, 32'd0);
    check("redir_nop", if_instr, 32'h13);
    check("redir_pc", pc_out, 32'd8);
    idle(1);
    check("redir_ifpc", if_pc, 32'd8);
    check("redir_valid", {31'd0, if_valid}, 32'd1);
    cycle(1'b1, 32'd20, 1'b1);
    check("redir_stall_pc", pc_out, 32'd20);
    check("redir_stall_bubble", {31'd0, if_valid}, 32'd0);
    idle(2);

    // Fault redirects from fresh resets; later redirects ignored.
    for (int k = 0; k < 2; k++) begin
      do_reset();
      idle(3);
      cycle(1'b1, (k == 0) ? 32'h6 : 32'h40, 1'b0);
      check("fault_flag", {31'd0, fetch_fault}, 32'd1);
      check("fault_pc", pc_out, 32'd8);
      check("fault_valid", {31'd0, if_valid}, 32'd0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 32'd0, 1'b0);
      check("halt_ignores_redir", pc_out, 32'd8);
    end

    // Asynchronous reset between edges in the middle of a stream.
    do_reset();
    idle(5);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_pc", pc_out, 32'd0);
    check("async_instr", if_instr, 32'h13);
    check("async_count", fetch_count, 32'd0);
    check("async_fault", {31'd0, fetch_fault}, 32'd0);
    check("async_valid", {31'd0, if_valid}, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    check_all();
    idle(1);
    check("async_boot", {31'd0, if_valid}, 32'd0);
    idle(1);
    check("async_restart", if_pc, 32'd0);
    check("async_restart_v", {31'd0, if_valid}, 32'd1);

    // Randomized sessions.
    for (int s = 0; s < 25; s++) begin
      do_reset();
      for (int i = 0; i < 40; i++) begin
        logic        rv, st;
        logic [31:0] tgt;
        rv  = ($urandom_range(0, 7) == 0);
        st  = ($urandom_range(0, 3) == 0);
        tgt = ($urandom_range(0, 5) == 0) ? m_pc : rand_target();
        cycle(rv, tgt, st);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch initiator for the single-cycle/pipelined RV32I core.
- Drives the byte-address PC into the combinational instruction memory and captures the returned word into an IF/ID register with a valid flag.
- Handles sequential PC+4 advance, branch/jal redirects, stall hold, and fault detection for misaligned or out-of-range fetches.
- Sits between the instruction memory and the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset; must be word-aligned.
- IMEM_DEPTH, 8, number of 32-bit words in instruction memory. The legal PC range is 0 .. 4*IMEM_DEPTH-4.
- NOP_INSTR, 32'h0000_0013, value loaded into if_instr on reset and bubbles (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  decode/hazard stall; holds PC and IF/ID register.
- redirect_valid  in  1  taken branch or jump resolved this cycle.
- redirect_target  in  32  byte address of the redirect.
- instr_in  in  32  word returned by instruction memory for pc_out (combinational, same cycle).
- pc_out  out  32  current fetch address to instruction memory.
- if_valid  out  1  IF/ID register holds a real instruction.
- if_pc  out  32  address of the instruction in IF/ID.
- if_pc_plus4  out  32  if_pc + 4, for jal/jalr link value.
- if_instr  out  32  captured instruction word.
- fetch_fault  out  1  sticky fault flag; fetch halted.
- fetch_count  out  32  number of instructions captured since reset, wraps modulo 2^32.

Behaviour:
- Reset is asynchronous and active-high; it is sampled at any time, including mid-operation. On reset:
  - pc = RESET_PC, state = BOOT.
  - if_valid = 0, if_pc = 0, if_pc_plus4 = 0, if_instr = NOP_INSTR.
  - fetch_fault = 0, fetch_count = 0.
- pc_out is the PC register directly; there is no combinational path from any input to pc_out.
- State machine: BOOT, RUN, HALT.
  - BOOT: lasts exactly one clock after reset deassert. pc_out = RESET_PC, no capture, if_valid stays 0. BOOT -> RUN unconditionally.
  - RUN, priority order per rising edge:
    1. redirect_valid = 1, stall ignored:
       - If redirect_target[1:0] != 0 or redirect_target >= 4*IMEM_DEPTH: pc unchanged, if_valid <= 0, fetch_fault <= 1, state -> HALT.
       - Otherwise: pc <= redirect_target, if_valid <= 0 (one bubble), if_instr <= NOP_INSTR.
    2. stall = 1: pc, IF/ID register and fetch_count all hold.
    3. pc >= 4*IMEM_DEPTH: no capture, if_valid <= 0, fetch_fault <= 1, state -> HALT.
    4. Normal fetch:
       - if_pc <= pc, if_pc_plus4 <= pc + 4, if_instr <= instr_in, if_valid <= 1.
       - pc <= pc + 4, fetch_count <= fetch_count + 1.
  - HALT: all registers hold. redirect_valid and stall are ignored. fetch_fault stays 1 and if_valid stays 0 until reset.
- Latency: the instruction at address A appears on if_instr one clock after pc_out = A, with no stall or redirect in that cycle.
- Redirect penalty: exactly one bubble cycle (if_valid = 0). The target instruction is valid on the second edge after redirect_valid is sampled.
- Arithmetic: pc + 4 is a 32-bit add that wraps silently. The range check catches any wrap before it is fetched.
- Simultaneous redirect and stall: the redirect wins and the stall is dropped for that cycle.
- Redirect to the current pc is legal: it produces one bubble, then a re-fetch.

Test Plan:
- Reset release, no stall, IMEM_DEPTH = 8:
  - if_valid = 0 for the BOOT cycle.
  - Then if_pc = 0, 4, 8, ... on consecutive cycles, with if_instr matching the memory words and if_pc_plus4 = if_pc + 4.
  - fetch_count = 8 after the word at 28.
  - pc = 32 next, then fetch_fault = 1 and HALT.
- Stall held 3 cycles while if_pc = 8:
  - if_pc, if_instr, pc_out = 12 and fetch_count all frozen for those 3 cycles.
  - Resumes with if_pc = 12 on the first unstalled edge.
- redirect_valid with target = 8 while pc_out = 16:
  - Next cycle if_valid = 0 and if_instr = 32'h13, pc_out = 8.
  - The cycle after, if_pc = 8, if_valid = 1.
- Redirect and stall asserted together, target = 20: pc_out = 20 next cycle and a bubble is inserted, showing the stall is ignored.
- Fault redirects, each from a fresh reset:
  - target = 32'h6 -> fetch_fault = 1, pc_out unchanged, if_valid = 0.
  - target = 32'h40 -> same response.
  - Subsequent redirects to 0 are ignored until reset.
- Reset asserted asynchronously mid-stream between clock edges:
  - Outputs return to reset values immediately: pc_out = RESET_PC, if_instr = 32'h13, count = 0, fault = 0.
  - After deassert, BOOT lasts one cycle, then fetch restarts at 0.
